// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared FSM states, op encodings and step-count helper for serial_addsub
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int steps_of(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// rtl/addsub_digit.sv - combinational DIGIT-wide add slice with carry out and carry into slice MSB
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign s    = full[DIGIT-1:0];
  assign cout = full[DIGIT];
  // carry entering the top bit falls out of the top bit's sum equation
  assign cmsb = a[DIGIT-1] ^ b[DIGIT-1] ^ full[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial add/sub with valid/ready and flags; SERIAL_ADDSUB_SAT_EN enables saturation
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = steps_of(WIDTH, DIGIT);
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic             carry, cout_r, ovf_r, zero_r;
  logic [DIGIT-1:0] a_sl, b_sl, d_sum;
  logic             d_cout, d_cmsb;
  logic [WIDTH-1:0] sum_fin, sum_res;
  logic             last, ovf_fin;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (cnt == CW'(i)) begin
        a_sl = a_r[i*DIGIT +: DIGIT];
        b_sl = b_r[i*DIGIT +: DIGIT];
      end
    end
  end

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .s    (d_sum),
    .cout (d_cout),
    .cmsb (d_cmsb)
  );

  always_comb begin
    sum_fin = sum_r;
    for (int i = 0; i < STEPS; i++) begin
      if (cnt == CW'(i)) sum_fin[i*DIGIT +: DIGIT] = d_sum;
    end
  end

  assign last    = (cnt == LAST);
  assign ovf_fin = d_cmsb ^ d_cout;

`ifdef SERIAL_ADDSUB_SAT_EN
  // clamp toward the sign of the latched a operand
  always_comb begin
    sum_res = sum_fin;
    if (ovf_fin) sum_res = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_res = sum_fin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && in_ready) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b ^ {WIDTH{sub}};
            carry <= (sub == OP_SUB);
            cnt   <= '0;
          end
        end
        RUN: begin
          carry <= d_cout;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum_r  <= sum_res;
            cout_r <= d_cout;
            ovf_r  <= ovf_fin;
            zero_r <= (sum_res == '0);
          end else begin
            sum_r  <= sum_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed scoreboard bench for serial_addsub (16/4 and 8/8 instances)
module tb_serial_addsub;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv = 1'b0, ir, sb = 1'b0, ov, ordy = 1'b0, co, of, zf;
  logic [15:0] a16 = '0, b16 = '0, s16;

  logic        e_iv = 1'b0, e_ir, e_sb = 1'b0, e_ov, e_ordy = 1'b0, e_co, e_of, e_zf;
  logic [7:0]  e_a = '0, e_b = '0, e_s;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a16), .b(b16), .sub(sb),
    .out_valid(ov), .out_ready(ordy), .sum(s16), .cout(co), .ovf(of), .zero(zf)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir), .a(e_a), .b(e_b), .sub(e_sb),
    .out_valid(e_ov), .out_ready(e_ordy), .sum(e_s), .cout(e_co), .ovf(e_of), .zero(e_zf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    exp_t        r;
    logic [15:0] yy;
    logic [16:0] full;
    yy     = s ? ~y : y;
    full   = {1'b0, x} + {1'b0, yy} + {16'b0, s};
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (x[15] == yy[15]) && (full[15] != x[15]);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (r.ovf) r.sum = x[15] ? 16'h8000 : 16'h7fff;
`endif
    r.zero = (r.sum == 16'h0);
    return r;
  endfunction

  task automatic start16(input logic [15:0] x, input logic [15:0] y, input logic s, input exp_t e);
    int t = 0;
    a16 = x; b16 = y; sb = s; iv = 1'b1;
    while (!ir && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("accept_ready", 32'(ir), 32'd1);
    @(posedge clk); #1;
    iv = 1'b0; a16 = ~x; b16 = ~y; sb = ~s;
    sbq.push_back(e);
  endtask

  task automatic wait16(input string tag);
    int   cyc = 0;
    exp_t e;
    while (!ov && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd4);
    if (sbq.size() == 0) begin
      check({tag, "_sbq"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check({tag, "_sum"},  32'(s16), 32'(e.sum));
      check({tag, "_cout"}, 32'(co),  32'(e.cout));
      check({tag, "_ovf"},  32'(of),  32'(e.ovf));
      check({tag, "_zero"}, 32'(zf),  32'(e.zero));
    end
  endtask

  task automatic release16(input string tag);
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    check({tag, "_ovdrop"}, 32'(ov), 32'd0);
    check({tag, "_irdy"},   32'(ir), 32'd1);
  endtask

  initial begin
    exp_t        e;
    logic [15:0] x, y;
    logic        s;
    int          cyc;

    #12;
    check("rst_in_ready", 32'(ir), 32'd0);
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_outs", {13'b0, co, of, zf, s16}, 32'd0);
    check("rst8_outs", {20'b0, e_ir, e_ov, e_co, e_of, e_s}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(ir), 32'd1);

    start16(16'h1234, 16'h0fff, 1'b0, '{16'h2233, 1'b0, 1'b0, 1'b0});
    wait16("add1");
    release16("add1");

    start16(16'h0005, 16'h0007, 1'b1, '{16'hfffe, 1'b0, 1'b0, 1'b0});
    wait16("sub_neg");
    release16("sub_neg");

    start16(16'h1234, 16'h1234, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1});
    wait16("sub_zero");
    release16("sub_zero");

`ifdef SERIAL_ADDSUB_SAT_EN
    e = '{16'h7fff, 1'b0, 1'b1, 1'b0};
`else
    e = '{16'h8000, 1'b0, 1'b1, 1'b0};
`endif
    start16(16'h7fff, 16'h0001, 1'b0, e);
    wait16("add_ovf");
    release16("add_ovf");

`ifdef SERIAL_ADDSUB_SAT_EN
    e = '{16'h8000, 1'b1, 1'b1, 1'b0};
`else
    e = '{16'h7fff, 1'b1, 1'b1, 1'b0};
`endif
    start16(16'h8000, 16'h0001, 1'b1, e);
    wait16("sub_ovf");
    release16("sub_ovf");

    // backpressure with ignored requests while DONE
    start16(16'h00ff, 16'h0001, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0});
    wait16("bp");
    for (int i = 0; i < 3; i++) begin
      iv = 1'b1; a16 = 16'haaaa; b16 = 16'h5555;
      @(posedge clk); #1;
      check("bp_hold_ov",  32'(ov),  32'd1);
      check("bp_hold_sum", 32'(s16), 32'h0100);
      check("bp_hold_ir",  32'(ir),  32'd0);
    end
    iv = 1'b0;
    release16("bp");
    @(posedge clk); #1;
    check("bp_no_stored_req", 32'(ir), 32'd1);

    for (int i = 0; i < 4; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      s = 1'($urandom);
      start16(x, y, s, model(x, y, s));
      wait16("rand");
      release16("rand");
    end

    // reset in the second RUN cycle
    start16(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_outs", {13'b0, co, of, zf, s16}, 32'd0);
    check("midrst_ov_ir", {30'b0, ov, ir}, 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_ir_after", 32'(ir), 32'd1);
    start16(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0});
    wait16("post_rst");
    release16("post_rst");

    // single-step instance
    e_a = 8'h80; e_b = 8'h80; e_sb = 1'b0; e_iv = 1'b1;
    check("s1_ready", 32'(e_ir), 32'd1);
    @(posedge clk); #1;
    e_iv = 1'b0; e_a = 8'h00; e_b = 8'h00;
    cyc = 0;
    while (!e_ov && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("s1_lat", 32'(cyc), 32'd1);
`ifdef SERIAL_ADDSUB_SAT_EN
    check("s1_sum",  32'(e_s),  32'h80);
    check("s1_zero", 32'(e_zf), 32'd0);
`else
    check("s1_sum",  32'(e_s),  32'h00);
    check("s1_zero", 32'(e_zf), 32'd1);
`endif
    check("s1_cout", 32'(e_co), 32'd1);
    check("s1_ovf",  32'(e_of), 32'd1);
    e_ordy = 1'b1;
    @(posedge clk); #1;
    e_ordy = 1'b0;
    check("s1_release", {30'b0, e_ov, e_ir}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised, multi-cycle signed/unsigned adder-subtractor. Generalises the fixed 4-bit ripple add/sub stage to WIDTH bits processed DIGIT bits per cycle. Adds valid/ready handshakes on both sides, plus registered carry, signed-overflow and zero flags. Sits between operand sources and result consumers in the datapath where area matters more than single-cycle latency.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per RUN cycle; STEPS = WIDTH/DIGIT (≥1).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept; high only in IDLE with rst low.
- a  in  WIDTH  minuend/addend.
- b  in  WIDTH  subtrahend/addend.
- sub  in  1  0 = a+b, 1 = a−b.
- out_valid  out  1  result registered and held.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  sum == 0 (post-saturation).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b XOR {WIDTH{sub}}, carry = sub, cnt = 0, and the sign of a → RUN.
- RUN:
  - Each cycle, add digit slice cnt of the latched operands with the stored carry.
  - Write the slice result into the result register and update carry.
  - On the last slice (cnt == STEPS−1), also capture the carry into the MSB.
  - cnt increments; after the slice at cnt == STEPS−1 → DONE.
- DONE:
  - out_valid = 1; sum/cout/ovf/zero stable.
  - On out_ready → IDLE.
- Flag definitions:
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
- Inputs a/b/sub are sampled only at the accept edge. Later changes have no effect.
- Reset (any time, including mid-RUN or in DONE) → IDLE. The in-flight operation is discarded and no result is produced.
- Reset values: state IDLE, out_valid 0, sum 0, cout 0, ovf 0, zero 0, in_ready 0 while rst is high.

## Timing
- Latency: accept at edge E0; RUN updates at E1..E_STEPS; out_valid high after E_STEPS, i.e. STEPS cycles after accept.
- out_valid deasserts on the edge where out_ready is sampled high. in_ready rises in the same cycle (IDLE).
- Throughput: one operation per STEPS+2 cycles with out_ready tied high.
- in_ready is combinational from state and rst only. It does not depend on in_valid.
- out_valid is a registered state decode and does not depend on out_ready.
- out_ready while not in DONE is ignored. in_valid outside IDLE is ignored and the request is not stored.
- STEPS == 1 is legal: RUN lasts one cycle.

## Configuration
- SERIAL_ADDSUB_SAT_EN defined: on entry to DONE with ovf = 1, sum is replaced by the saturation value.
  - Latched sign of a = 0 → 0111…1.
  - Latched sign of a = 1 → 1000…0.
  - ovf still reports 1, cout is unchanged, and zero is computed on the saturated value.
- Undefined: sum is the wrapped modulo-2^WIDTH result. No extra logic is present.

## Structure
- Package addsub_pkg: FSM state enum (IDLE/RUN/DONE), op-encoding constants (OP_ADD = 0, OP_SUB = 1), and a STEPS helper function.
- Sub-module addsub_digit (combinational, DIGIT-wide):
  - Inputs: a slice, b slice, cin.
  - Outputs: sum slice, cout, and carry into the slice MSB for overflow.
- serial_addsub instantiates one addsub_digit and holds the FSM, counter and registers.

## Test plan
- WIDTH = 16, DIGIT = 4, add 0x1234 + 0x0FFF → sum 0x2233, cout 0, ovf 0, zero 0; out_valid exactly 4 cycles after accept.
- Subtract 0x0005 − 0x0007 → 0xFFFE, cout 0, ovf 0. Subtract 0x1234 − 0x1234 → 0x0000, cout 1, zero 1.
- Add 0x7FFF + 0x0001 → ovf 1; sum 0x8000 without the macro, 0x7FFF with SERIAL_ADDSUB_SAT_EN. Subtract 0x8000 − 0x0001 → ovf 1; sum 0x7FFF without the macro, 0x8000 with it.
- Backpressure: out_ready low 3 cycles in DONE → sum and flags stable, in_ready 0, and in_valid pulses are ignored. Release → IDLE the next cycle.
- Reset asserted during the 2nd RUN cycle → all outputs 0 immediately, in_ready 1 after release, and a fresh 0x0001 + 0x0001 yields 0x0002.
- WIDTH = 8, DIGIT = 8 (STEPS = 1): 0x80 + 0x80 → sum 0x00, cout 1, ovf 1, zero 1 (no macro), out_valid 1 cycle after accept.
